// File: rtl/fetch_queue_if.sv
// Fetch queue bus: PC unit request, instruction memory request/response, decode handshake.
interface fetch_queue_if;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic        dec_valid_o;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pc_o;
    logic        dec_ready_i;

    // Queue side
    modport slave (
        input  pc_i, pc_valid_i, flush_i, imem_req_ready_i,
        input  imem_resp_valid_i, imem_resp_data_i, dec_ready_i,
        output pc_ready_o, imem_req_valid_o, imem_req_addr_o,
        output dec_valid_o, dec_instr_o, dec_pc_o
    );

    // PC unit / memory / decode side
    modport master (
        output pc_i, pc_valid_i, flush_i, imem_req_ready_i,
        output imem_resp_valid_i, imem_resp_data_i, dec_ready_i,
        input  pc_ready_o, imem_req_valid_o, imem_req_addr_o,
        input  dec_valid_o, dec_instr_o, dec_pc_o
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues PCs to memory, pairs in-order responses with
// their PCs, and hands instruction/PC pairs to decode. A redirect drops queued
// entries and counts in-flight responses that must be thrown away.
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW:0]   DEPTH_U = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0] alloc_q, alloc_d;
    logic [PW-1:0] fill_q, fill_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic [PW-1:0] occupancy;
    logic [PW-1:0] in_flight;
    logic [PW:0]   used;
    logic          credit;
    logic          req_fire;
    logic          resp_fill;
    logic          dec_valid;
    logic          pop;

    // Credit counts both live entries and responses still owed to a dropped fetch,
    // so a refill can never overrun slots that in-flight garbage will land in.
    always_comb begin
        occupancy = alloc_q - head_q;
        in_flight = alloc_q - fill_q;
        used      = {1'b0, occupancy} + {1'b0, drop_cnt_q};
        credit    = (used < DEPTH_U);
        req_fire  = bus.pc_valid_i & bus.imem_req_ready_i & credit & ~bus.flush_i;
        resp_fill = bus.imem_resp_valid_i & (drop_cnt_q == '0) & ~bus.flush_i;
        dec_valid = (head_q != fill_q);
        pop       = dec_valid & bus.dec_ready_i;
    end

    assign bus.imem_req_valid_o = bus.pc_valid_i & credit & ~bus.flush_i;
    assign bus.imem_req_addr_o  = bus.pc_i;
    assign bus.pc_ready_o       = bus.imem_req_ready_i & credit & ~bus.flush_i;
    assign bus.dec_valid_o      = dec_valid;
    assign bus.dec_instr_o      = instr_mem_q[head_q[AW-1:0]];
    assign bus.dec_pc_o         = pc_mem_q[head_q[AW-1:0]];

    // Pointer and drop-count next state; a flush overrides every other update.
    always_comb begin
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        head_d     = head_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.flush_i) begin
            head_d     = alloc_q;
            fill_d     = alloc_q;
            drop_cnt_d = drop_cnt_q + in_flight
                       - (bus.imem_resp_valid_i ? PTR_ONE : '0);
        end else begin
            if (req_fire) begin
                alloc_d = alloc_q + PTR_ONE;
            end
            if (bus.imem_resp_valid_i) begin
                if (drop_cnt_q == '0) begin
                    fill_d = fill_q + PTR_ONE;
                end else begin
                    drop_cnt_d = drop_cnt_q - PTR_ONE;
                end
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
        end
    end

    // Pointer and drop-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_q    <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            head_q     <= head_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage: PC written on request accept, instruction on a kept response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                pc_mem_q[alloc_q[AW-1:0]] <= bus.pc_i;
            end
            if (resp_fill) begin
                instr_mem_q[fill_q[AW-1:0]] <= bus.imem_resp_data_i;
            end
        end
    end

    // A response with nothing outstanding and nothing to drop means the memory
    // returned more than it was asked for.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_resp_valid_i && (fill_q == alloc_q) && (drop_cnt_q == '0)));

endmodule
